dlx_reg_scoreboard: RTL

Register-hazard scoreboard for the DLX pipeline: the consumer side of destination-register selection. The decode stage reports each instruction's source registers and its selected 5-bit destination address at issue. Write-back returns the same address when the result is committed. The block tracks pending writes per register and raises a combinational stall whenever a source operand, or a saturated destination, is not yet safe.

---
 rtl/dlx_pkg.sv | 17 +
 rtl/sb_reg_counter.sv | 47 ++++
 rtl/dlx_reg_scoreboard.sv | 96 +++++++++
 3 files changed

// File: rtl/dlx_pkg.sv
// Shared DLX definitions: register-file geometry and the register-address type.
// Imported by the hazard scoreboard and its per-register counters.
package dlx_pkg;

  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 32;
  localparam int CNT_W    = 2;

  typedef logic [ADDR_W-1:0] reg_addr_t;

  localparam reg_addr_t REG_ZERO = 5'd0;

  function automatic logic is_reg_zero(input reg_addr_t a);
    return a == REG_ZERO;
  endfunction

endpackage

// File: rtl/sb_reg_counter.sv
// Saturating pending-write counter for one architectural register.
// Clear dominates; simultaneous inc and dec cancel out.
module sb_reg_counter #(
  parameter int CNT_W = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc_i,
  input  logic dec_i,
  input  logic clr_i,
  output logic nz_o,
  output logic one_o,
  output logic sat_o,
  output logic underflow_o
);

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d       = cnt_q;
    underflow_o = 1'b0;
    if (clr_i) begin
      cnt_d = CNT_ZERO;
    end else if (inc_i && !dec_i) begin
      // Never wrap; the structural stall normally keeps inc away from saturation.
      if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_ONE;
    end else if (dec_i && !inc_i) begin
      if (cnt_q == CNT_ZERO) underflow_o = 1'b1;
      else                   cnt_d = cnt_q - CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= CNT_ZERO;
    else        cnt_q <= cnt_d;
  end

  assign nz_o  = (cnt_q != CNT_ZERO);
  assign one_o = (cnt_q == CNT_ONE);
  assign sat_o = (cnt_q == CNT_MAX);

endmodule

// File: rtl/dlx_reg_scoreboard.sv
// Register-hazard scoreboard: counts in-flight writes per register and stalls
// issue while a source is pending or a destination counter is saturated.
module dlx_reg_scoreboard
  import dlx_pkg::*;
#(
  parameter int NUM_REGS = dlx_pkg::NUM_REGS,
  parameter int ADDR_W   = dlx_pkg::ADDR_W,
  parameter int CNT_W    = dlx_pkg::CNT_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                issue_valid,
  input  logic [ADDR_W-1:0]   issue_rs1,
  input  logic                issue_use_rs1,
  input  logic [ADDR_W-1:0]   issue_rs2,
  input  logic                issue_use_rs2,
  input  logic                issue_we,
  input  logic [ADDR_W-1:0]   issue_rd,
  input  logic                wb_valid,
  input  logic [ADDR_W-1:0]   wb_rd,
  input  logic                flush,
  output logic                stall,
  output logic [NUM_REGS-1:0] busy_mask,
  output logic                idle,
  output logic                err_underflow
);

  logic [NUM_REGS-1:0] nz_vec;
  logic [NUM_REGS-1:0] one_vec;
  logic [NUM_REGS-1:0] sat_vec;
  logic [NUM_REGS-1:0] uf_vec;

  logic accept;
  logic haz_rs1;
  logic haz_rs2;
  logic haz_struct;
  logic err_q;
  logic err_d;

  // R0 is hardwired zero, so its slot carries constant flags and no counter.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
      if (gi == 0) begin : g_zero
        assign nz_vec[gi]  = 1'b0;
        assign one_vec[gi] = 1'b0;
        assign sat_vec[gi] = 1'b0;
        assign uf_vec[gi]  = 1'b0;
      end else begin : g_cnt
        logic inc;
        logic dec;
        assign inc = accept && (issue_rd == ADDR_W'(gi));
        assign dec = wb_valid && (wb_rd == ADDR_W'(gi));
        sb_reg_counter #(
          .CNT_W(CNT_W)
        ) u_cnt (
          .clk        (clk),
          .rst_n      (rst_n),
          .inc_i      (inc),
          .dec_i      (dec),
          .clr_i      (flush),
          .nz_o       (nz_vec[gi]),
          .one_o      (one_vec[gi]),
          .sat_o      (sat_vec[gi]),
          .underflow_o(uf_vec[gi])
        );
      end
    end
  endgenerate

  // A last pending write committing this cycle is forwarded by the register
  // file (write-before-read), so it does not block the reader.
  always_comb begin
    haz_rs1 = issue_use_rs1 && (issue_rs1 != REG_ZERO) && nz_vec[issue_rs1] &&
              !(wb_valid && (wb_rd == issue_rs1) && one_vec[issue_rs1]);
    haz_rs2 = issue_use_rs2 && (issue_rs2 != REG_ZERO) && nz_vec[issue_rs2] &&
              !(wb_valid && (wb_rd == issue_rs2) && one_vec[issue_rs2]);
    haz_struct = issue_we && (issue_rd != REG_ZERO) && sat_vec[issue_rd] &&
                 !(wb_valid && (wb_rd == issue_rd));
  end

  assign stall  = issue_valid && (haz_rs1 || haz_rs2 || haz_struct);
  assign accept = issue_valid && !stall && issue_we && (issue_rd != REG_ZERO);

  assign err_d = err_q || (|uf_vec);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_d;
  end

  assign err_underflow = err_q;
  assign busy_mask     = nz_vec;
  assign idle          = ~(|nz_vec);

endmodule
